// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic MID_IFU = 1'b0;
    localparam logic MID_LSU = 1'b1;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle; master drives requests, slave drives ready/response.
interface axi4_lite_interface #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the prio index wins.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic       o_valid,
    output logic       o_grant
);

    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = i_prio;
        end else begin
            o_grant = i_req[1];
        end
    end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4-Lite arbiter, one transaction outstanding,
// round-robin on ties, read preferred over write within the winning master.
module axi4_lite_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    axi4_lite_interface.slave  m0,
    axi4_lite_interface.slave  m1,
    axi4_lite_interface.master s
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_t r_state;
    logic       r_grant;
    logic       r_prio;
    logic       r_aw_done;
    logic       r_w_done;

    logic [1:0] w_rd_req;
    logic [1:0] w_wr_req;
    logic [1:0] w_req;
    logic       w_pick_valid;
    logic       w_pick;

    assign w_rd_req = {m1.arvalid, m0.arvalid};
    assign w_wr_req = {m1.awvalid | m1.wvalid, m0.awvalid | m0.wvalid};
    assign w_req    = w_rd_req | w_wr_req;

    rr_pick2 u_pick (
        .i_req   (w_req),
        .i_prio  (r_prio),
        .o_valid (w_pick_valid),
        .o_grant (w_pick)
    );

    // Request side of whichever master currently holds the grant
    logic                  w_sel1;
    logic                  w_sel0;
    logic [ADDR_WIDTH-1:0] w_g_araddr;
    logic [ADDR_WIDTH-1:0] w_g_awaddr;
    logic [DATA_WIDTH-1:0] w_g_wdata;
    logic [STRB_WIDTH-1:0] w_g_wstrb;
    logic                  w_g_arvalid;
    logic                  w_g_awvalid;
    logic                  w_g_wvalid;
    logic                  w_g_rready;
    logic                  w_g_bready;

    assign w_sel1      = (r_grant == MID_LSU);
    assign w_sel0      = (r_grant == MID_IFU);
    assign w_g_araddr  = w_sel1 ? m1.araddr  : m0.araddr;
    assign w_g_awaddr  = w_sel1 ? m1.awaddr  : m0.awaddr;
    assign w_g_wdata   = w_sel1 ? m1.wdata   : m0.wdata;
    assign w_g_wstrb   = w_sel1 ? m1.wstrb   : m0.wstrb;
    assign w_g_arvalid = w_sel1 ? m1.arvalid : m0.arvalid;
    assign w_g_awvalid = w_sel1 ? m1.awvalid : m0.awvalid;
    assign w_g_wvalid  = w_sel1 ? m1.wvalid  : m0.wvalid;
    assign w_g_rready  = w_sel1 ? m1.rready  : m0.rready;
    assign w_g_bready  = w_sel1 ? m1.bready  : m0.bready;

    logic w_st_rd_addr;
    logic w_st_rd_data;
    logic w_st_wr;
    logic w_st_wr_resp;

    assign w_st_rd_addr = (r_state == RD_ADDR);
    assign w_st_rd_data = (r_state == RD_DATA);
    assign w_st_wr      = (r_state == WR);
    assign w_st_wr_resp = (r_state == WR_RESP);

    logic w_s_arvalid;
    logic w_s_rready;
    logic w_s_awvalid;
    logic w_s_wvalid;
    logic w_s_bready;

    // Once a write channel has handshaken it is masked until the response phase
    assign w_s_arvalid = w_st_rd_addr & w_g_arvalid;
    assign w_s_rready  = w_st_rd_data & w_g_rready;
    assign w_s_awvalid = w_st_wr & w_g_awvalid & ~r_aw_done;
    assign w_s_wvalid  = w_st_wr & w_g_wvalid & ~r_w_done;
    assign w_s_bready  = w_st_wr_resp & w_g_bready;

    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;

    assign w_ar_hs = w_s_arvalid & s.arready;
    assign w_r_hs  = s.rvalid & w_s_rready;
    assign w_aw_hs = w_s_awvalid & s.awready;
    assign w_w_hs  = w_s_wvalid & s.wready;
    assign w_b_hs  = s.bvalid & w_s_bready;

    assign s.araddr  = w_g_araddr;
    assign s.arvalid = w_s_arvalid;
    assign s.rready  = w_s_rready;
    assign s.awaddr  = w_g_awaddr;
    assign s.awvalid = w_s_awvalid;
    assign s.wdata   = w_g_wdata;
    assign s.wstrb   = w_g_wstrb;
    assign s.wvalid  = w_s_wvalid;
    assign s.bready  = w_s_bready;

    assign m0.arready = w_sel0 & w_st_rd_addr & s.arready;
    assign m0.awready = w_sel0 & w_st_wr & ~r_aw_done & s.awready;
    assign m0.wready  = w_sel0 & w_st_wr & ~r_w_done & s.wready;
    assign m0.rvalid  = w_sel0 & w_st_rd_data & s.rvalid;
    assign m0.bvalid  = w_sel0 & w_st_wr_resp & s.bvalid;
    assign m0.rdata   = s.rdata;
    assign m0.rresp   = s.rresp;
    assign m0.bresp   = s.bresp;

    assign m1.arready = w_sel1 & w_st_rd_addr & s.arready;
    assign m1.awready = w_sel1 & w_st_wr & ~r_aw_done & s.awready;
    assign m1.wready  = w_sel1 & w_st_wr & ~r_w_done & s.wready;
    assign m1.rvalid  = w_sel1 & w_st_rd_data & s.rvalid;
    assign m1.bvalid  = w_sel1 & w_st_wr_resp & s.bvalid;
    assign m1.rdata   = s.rdata;
    assign m1.rresp   = s.rresp;
    assign m1.bresp   = s.bresp;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_grant   <= MID_IFU;
            r_prio    <= MID_IFU;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick;
                        r_state <= w_rd_req[w_pick] ? RD_ADDR : WR;
                    end
                end
                RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_r_hs) begin
                        r_state <= IDLE;
                        r_prio  <= ~r_grant;
                    end
                end
                WR: begin
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                        r_state   <= WR_RESP;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_w_done <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (w_b_hs) begin
                        r_state <= IDLE;
                        r_prio  <= ~r_grant;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
